// File: rtl/uart2wb_word_if.sv
// Bus-side handshake between the UART command parser and the bus master:
// a 34-bit command word, its one-cycle valid strobe and the downstream stall.
interface uart2wb_word_if;
  logic [33:0] out_UART2WB_word;
  logic        out_UART2WB_cyc;
  logic        in_UART2WB_stall;

  modport master (
    output out_UART2WB_word,
    output out_UART2WB_cyc,
    input  in_UART2WB_stall
  );

  modport slave (
    input  out_UART2WB_word,
    input  out_UART2WB_cyc,
    output in_UART2WB_stall
  );
endinterface

// File: rtl/uart2wb_word.sv
// Parses 'R'/'W' + 8 hex digit ASCII frames from a UART receiver into 34-bit
// command words, with a single-cycle strobe, stall hold-off and error flags.
module uart2wb_word #(
  parameter int unsigned TIMEOUT_CYCLES   = 1000000,
  parameter bit          ACCEPT_UPPER_HEX = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_DataByte,
  input  logic                  in_fComplete,
  uart2wb_word_if.master        bus,
  output logic                  out_err,
  output logic                  out_ovf,
  output logic                  out_busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEX  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Returns {valid, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if ((b >= 8'h30) && (b <= 8'h39)) begin
      return {1'b1, b[3:0]};
    end else if ((b >= 8'h61) && (b <= 8'h66)) begin
      return {1'b1, b[3:0] + 4'd9};
    end else if (ACCEPT_UPPER_HEX && (b >= 8'h41) && (b <= 8'h46)) begin
      return {1'b1, b[3:0] + 4'd9};
    end else begin
      return 5'd0;
    end
  endfunction

  state_t        state_q, state_d;
  logic          rw_q, rw_d;
  logic [31:0]   shift_q, shift_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          fc_q, fc_d;
  logic [33:0]   word_q, word_d;
  logic          cyc_q, cyc_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;

  logic          accept_s;
  logic [4:0]    dec_s;
  logic          is_rw_s;
  logic [31:0]   shift_next_s;

  assign accept_s     = in_fComplete & ~fc_q;
  assign dec_s        = hex_decode(in_DataByte);
  assign is_rw_s      = (in_DataByte == 8'h52) || (in_DataByte == 8'h57);
  assign shift_next_s = {shift_q[27:0], dec_s[3:0]};

  // Next-state and output computation for the frame parser.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    fc_d    = in_fComplete;
    word_d  = word_q;
    cyc_d   = 1'b0;
    err_d   = 1'b0;
    ovf_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (accept_s && is_rw_s) begin
          rw_d    = (in_DataByte == 8'h57);
          shift_d = 32'd0;
          cnt_d   = 4'd0;
          state_d = ST_HEX;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HEX: begin
        if (accept_s) begin
          // Any accepted byte restarts the inter-character timer, even on expiry.
          tmo_d = '0;
          if (dec_s[4]) begin
            shift_d = shift_next_s;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (bus.in_UART2WB_stall) begin
                state_d = ST_HOLD;
              end else begin
                word_d  = {1'b0, rw_q, shift_next_s};
                cyc_d   = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              state_d = ST_HEX;
            end
          end else if (is_rw_s) begin
            err_d   = 1'b1;
            rw_d    = (in_DataByte == 8'h57);
            shift_d = 32'd0;
            cnt_d   = 4'd0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_HOLD: begin
        tmo_d = '0;
        if (accept_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = 1'b0;
        end
        if (!bus.in_UART2WB_stall) begin
          word_d  = {1'b0, rw_q, shift_q};
          cyc_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_HEX) || (state_d == ST_HOLD);
  end

  // State and registered outputs; rst is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      shift_q <= 32'd0;
      cnt_q   <= 4'd0;
      tmo_q   <= '0;
      fc_q    <= 1'b0;
      word_q  <= 34'd0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      fc_q    <= fc_d;
      word_q  <= word_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out_UART2WB_word = word_q;
  assign bus.out_UART2WB_cyc  = cyc_q;
  assign out_err              = err_q;
  assign out_ovf              = ovf_q;
  assign out_busy             = busy_q;

endmodule

// File: tb/tb_uart2wb_word.sv
// Scoreboard bench for uart2wb_word: directed frames from the test plan plus
// randomized byte streams checked against a string-level parser model.
module tb_uart2wb_word;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_byte;
  logic       fcomplete;
  logic       err;
  logic       ovf;
  logic       busy;

  uart2wb_word_if bus ();

  uart2wb_word #(
    .TIMEOUT_CYCLES   (20),
    .ACCEPT_UPPER_HEX (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_DataByte  (data_byte),
    .in_fComplete (fcomplete),
    .bus          (bus),
    .out_err      (err),
    .out_ovf      (ovf),
    .out_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] word;
    int          cycle;
  } exp_t;

  exp_t        exp_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          cyc_cnt = 0;
  int          obs_err = 0;
  int          obs_ovf = 0;
  int          exp_err = 0;
  int          exp_ovf = 0;
  logic [33:0] last_word = 34'd0;

  // Reference parser state (operates on whole bytes, no timing).
  bit          m_in_frame = 1'b0;
  bit          m_rw       = 1'b0;
  int          m_n        = 0;
  logic [31:0] m_val      = 32'd0;
  bit          m_pending  = 1'b0;
  logic [33:0] m_pend_word = 34'd0;
  int          acc_cycle  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc_cnt);
    end
  endfunction

  function automatic logic [7:0] hex_char(int v, bit up);
    logic [7:0] base;
    if (v < 10) return 8'h30 + 8'(v);
    base = up ? 8'h41 : 8'h61;
    return base + 8'(v - 10);
  endfunction

  function automatic void model_feed(logic [7:0] b);
    bit is_rw;
    int nib;
    is_rw = (b == "R") || (b == "W");
    nib = -1;
    if (b >= "0" && b <= "9") nib = int'(b) - int'("0");
    if (b >= "a" && b <= "f") nib = int'(b) - int'("a") + 10;
    if (b >= "A" && b <= "F") nib = int'(b) - int'("A") + 10;
    if (m_pending) begin
      exp_ovf++;
    end else if (!m_in_frame) begin
      if (is_rw) begin
        m_in_frame = 1'b1;
        m_rw = (b == "W");
        m_n = 0;
        m_val = 32'd0;
      end
    end else if (nib >= 0) begin
      m_val = m_val * 32'd16 + 32'(nib);
      m_n++;
      if (m_n == 8) begin
        m_in_frame = 1'b0;
        if (bus.in_UART2WB_stall) begin
          m_pending = 1'b1;
          m_pend_word = {1'b0, m_rw, m_val};
        end else begin
          exp_q.push_back('{word: {1'b0, m_rw, m_val}, cycle: acc_cycle});
        end
      end
    end else if (is_rw) begin
      exp_err++;
      m_rw = (b == "W");
      m_n = 0;
      m_val = 32'd0;
    end else begin
      exp_err++;
      m_in_frame = 1'b0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk);
    #1;
    acc_cycle = cyc_cnt + 1;
    model_feed(b);
    data_byte = b;
    fcomplete = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    fcomplete = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold, 0);
  endtask

  task automatic checkpoint(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_err_count"}, 64'(obs_err), 64'(exp_err));
    check({tag, "_ovf_count"}, 64'(obs_ovf), 64'(exp_ovf));
  endtask

  // Monitor: pops the scoreboard on every strobe and tracks pulses.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (err) obs_err++;
      if (ovf) obs_ovf++;
      if (bus.out_UART2WB_cyc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cyc: got strobe with word %0h, expected none (cycle %0d)",
                   bus.out_UART2WB_word, cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          check("cyc_word", 64'(bus.out_UART2WB_word), 64'(e.word));
          check("cyc_latency", 64'(cyc_cnt), 64'(e.cycle));
          last_word = e.word;
        end
      end else begin
        check("word_stable", 64'(bus.out_UART2WB_word), 64'(last_word));
      end
    end
  end

  initial begin
    logic [7:0] junk [0:4];
    logic [7:0] bad  [0:3];
    int r;
    junk[0] = 8'h20; junk[1] = 8'h0D; junk[2] = 8'h0A; junk[3] = "x"; junk[4] = "5";
    bad[0]  = "g";   bad[1]  = "x";   bad[2]  = 8'h20; bad[3]  = ":";

    rst = 1'b1;
    data_byte = 8'h00;
    fcomplete = 1'b0;
    bus.in_UART2WB_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_word", 64'(bus.out_UART2WB_word), 64'd0);
    check("reset_cyc", 64'(bus.out_UART2WB_cyc), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    send_str("W1234abcd", 1);
    repeat (3) @(posedge clk);
    checkpoint("basic_write");
    check("basic_busy_idle", 64'(busy), 64'd0);

    send_str("R00FF00FF", 5);
    repeat (3) @(posedge clk);
    checkpoint("held_level");

    send_str("W12g", 1);
    repeat (2) @(posedge clk);
    checkpoint("bad_char");
    check("bad_char_busy", 64'(busy), 64'd0);
    send_str("R00000001", 2);
    repeat (3) @(posedge clk);
    checkpoint("after_bad");

    send_str("W12R87654321", 1);
    repeat (3) @(posedge clk);
    checkpoint("resync");

    bus.in_UART2WB_stall = 1'b1;
    send_str("Wdeadbeef", 1);
    send_byte("x", 1, 3);
    checkpoint("stall_ovf");
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_pending_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back('{word: m_pend_word, cycle: cyc_cnt + 1});
    m_pending = 1'b0;
    bus.in_UART2WB_stall = 1'b0;
    repeat (3) @(posedge clk);
    checkpoint("stall_release");
    check("stall_busy_after", 64'(busy), 64'd0);

    send_str("W12", 1);
    repeat (18) @(posedge clk);
    checkpoint("timeout_early");
    repeat (6) @(posedge clk);
    exp_err++;
    m_in_frame = 1'b0;
    checkpoint("timeout");
    check("timeout_busy", 64'(busy), 64'd0);

    send_str("W1234", 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_in_frame = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_word", 64'(bus.out_UART2WB_word), 64'd0);
    check("midrst_cyc", 64'(bus.out_UART2WB_cyc), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    last_word = 34'd0;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    checkpoint("after_midrst");

    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(3) == 0) send_byte(junk[$urandom_range(4)], 1, $urandom_range(3));
      send_byte($urandom_range(1) ? 8'h57 : 8'h52, $urandom_range(1, 4), $urandom_range(3));
      for (int d = 0; d < 8; d++) begin
        r = $urandom_range(15);
        if (r == 0) begin
          send_byte(bad[$urandom_range(3)], $urandom_range(1, 4), $urandom_range(3));
        end else if (r == 1) begin
          send_byte($urandom_range(1) ? 8'h57 : 8'h52, $urandom_range(1, 4), $urandom_range(3));
        end else begin
          send_byte(hex_char($urandom_range(15), 1'($urandom_range(1))),
                    $urandom_range(1, 4), $urandom_range(3));
        end
      end
    end
    repeat (30) @(posedge clk);
    if (m_in_frame) begin
      exp_err++;
      m_in_frame = 1'b0;
    end
    checkpoint("random");
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
